// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and its surroundings.
// The supervisor sits on the slave side; the PLL/system side is the master.
interface pll_lock_supervisor_if #(
    parameter int CNT_W = 8
);
    logic             pll_locked;
    logic             pll_resetb;
    logic             sys_reset;
    logic             ready;
    logic [2:0]       state_dbg;
    logic [CNT_W-1:0] timeout_count;
    logic [CNT_W-1:0] lost_count;

    modport slave (
        input  pll_locked,
        output pll_resetb, sys_reset, ready, state_dbg, timeout_count, lost_count
    );

    modport master (
        output pll_locked,
        input  pll_resetb, sys_reset, ready, state_dbg, timeout_count, lost_count
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Qualifies the PLL LOCK signal, sequences PLL RESETB and the downstream system
// reset, and keeps saturating debug counts of lock timeouts and lock losses.
module pll_lock_supervisor #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 256,
    parameter int CNT_W          = 8
) (
    input  logic                   clock_in,
    input  logic                   reset,
    pll_lock_supervisor_if.slave   bus
);
    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        HOLD      = 3'd3,
        RUN       = 3'd4
    } state_t;

    localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B   = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = (MAX_CYC <= 2) ? 1 : $clog2(MAX_CYC);

    localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cyc_q, cyc_d;
    logic [CNT_W-1:0]       tmo_q, tmo_d;
    logic [CNT_W-1:0]       lost_q, lost_d;
    logic                   pll_resetb_q;
    logic                   sys_reset_q;
    logic                   ready_q;

    // LOCK synchroniser into the oscillator domain
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    // Next-state, shared cycle counter and debug counter updates
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        lost_d  = lost_q;
        cyc_d   = cyc_q;
        case (state_q)
            PLL_RST: begin
                if (cyc_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                end else begin
                    state_d = PLL_RST;
                end
            end
            WAIT_LOCK: begin
                // A lock seen on the last window cycle still wins over the timeout
                if (locked_s) begin
                    state_d = STABLE;
                end else if (cyc_q == TMO_LAST) begin
                    state_d = PLL_RST;
                    tmo_d   = sat_inc(tmo_q);
                end else begin
                    state_d = WAIT_LOCK;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (cyc_q == STABLE_LAST) begin
                    state_d = HOLD;
                end else begin
                    state_d = STABLE;
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (cyc_q == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    state_d = HOLD;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = PLL_RST;
                    lost_d  = sat_inc(lost_q);
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = PLL_RST;
            end
        endcase
        // RUN has no time limit, so the counter is frozen there rather than wrapping
        if (state_d != state_q) begin
            cyc_d = {CW{1'b0}};
        end else if (state_q == RUN) begin
            cyc_d = cyc_q;
        end else begin
            cyc_d = cyc_q + CW'(1);
        end
    end

    // State, counters and registered outputs decoded from the next state
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q      <= PLL_RST;
            cyc_q        <= {CW{1'b0}};
            tmo_q        <= {CNT_W{1'b0}};
            lost_q       <= {CNT_W{1'b0}};
            pll_resetb_q <= 1'b0;
            sys_reset_q  <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            tmo_q        <= tmo_d;
            lost_q       <= lost_d;
            pll_resetb_q <= (state_d != PLL_RST);
            sys_reset_q  <= (state_d != RUN);
            ready_q      <= (state_d == RUN);
        end
    end

    assign bus.pll_resetb    = pll_resetb_q;
    assign bus.sys_reset     = sys_reset_q;
    assign bus.ready         = ready_q;
    assign bus.state_dbg     = state_q;
    assign bus.timeout_count = tmo_q;
    assign bus.lost_count    = lost_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed vector table, hand-written
// corner sequences and randomized LOCK activity checked against a phase-duration model.
module tb_pll_lock_supervisor;
    localparam int SYNC  = 2;
    localparam int PRC   = 4;
    localparam int LT    = 32;
    localparam int SC    = 8;
    localparam int HC    = 4;
    localparam int CW    = 4;
    localparam int SAT   = (1 << CW) - 1;

    logic clk;
    logic rst;

    pll_lock_supervisor_if #(.CNT_W(CW)) bus_if ();

    pll_lock_supervisor #(
        .SYNC_STAGES(SYNC), .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(LT),
        .STABLE_CYCLES(SC), .HOLD_CYCLES(HC), .CNT_W(CW)
    ) dut (
        .clock_in(clk),
        .reset(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: phase index with a time-in-phase count against a duration table
    int   m_ph, m_t, m_tc, m_lc;
    int   dur [5];
    logic hist [$];

    typedef struct {
        logic pin;
        int   n;
        int   st, rb, sr, rdy, tc, lc;
    } vec_t;
    vec_t vt [$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_t = 0; m_tc = 0; m_lc = 0;
        hist.delete();
        for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
    endtask

    task automatic model_step(input logic p);
        logic ls;
        int   nxt;
        bit   done;
        ls = hist.pop_front();
        hist.push_back(p);
        nxt  = m_ph;
        done = (m_t + 1 == dur[m_ph]);
        if (m_ph == 0) begin
            if (done) nxt = 1;
        end else if (m_ph == 1) begin
            if (ls) nxt = 2;
            else if (done) begin nxt = 0; if (m_tc < SAT) m_tc++; end
        end else if (m_ph == 4) begin
            if (!ls) begin nxt = 0; if (m_lc < SAT) m_lc++; end
        end else begin
            if (!ls) nxt = 1;
            else if (done) nxt = m_ph + 1;
        end
        m_t  = (nxt != m_ph) ? 0 : m_t + 1;
        m_ph = nxt;
    endtask

    task automatic cmp_model();
        chk("state", int'(bus_if.state_dbg), m_ph);
        chk("pll_resetb", int'(bus_if.pll_resetb), (m_ph != 0) ? 1 : 0);
        chk("sys_reset", int'(bus_if.sys_reset), (m_ph != 4) ? 1 : 0);
        chk("ready", int'(bus_if.ready), (m_ph == 4) ? 1 : 0);
        chk("timeout_count", int'(bus_if.timeout_count), m_tc);
        chk("lost_count", int'(bus_if.lost_count), m_lc);
    endtask

    task automatic chk_rst(input string nm);
        chk({nm, "_state"}, int'(bus_if.state_dbg), 0);
        chk({nm, "_pll_resetb"}, int'(bus_if.pll_resetb), 0);
        chk({nm, "_sys_reset"}, int'(bus_if.sys_reset), 1);
        chk({nm, "_ready"}, int'(bus_if.ready), 0);
        chk({nm, "_tc"}, int'(bus_if.timeout_count), 0);
        chk({nm, "_lc"}, int'(bus_if.lost_count), 0);
    endtask

    task automatic tick(input logic p);
        bus_if.pll_locked = p;
        @(posedge clk);
        model_step(p);
        #1;
        cmp_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk_rst("reset");
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic midop_reset(input string nm);
        #2 rst = 1'b1;
        #1;
        chk_rst(nm);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        logic v;
        int len;

        dur[0] = PRC; dur[1] = LT; dur[2] = SC; dur[3] = HC; dur[4] = 0;
        rst = 1'b1;
        bus_if.pll_locked = 1'b1;
        model_reset();

        // Lock present from the start, then a 3-cycle drop in RUN and relock
        vt.push_back('{1'b1, 3,  0, 0, 1, 0, 0, 0});
        vt.push_back('{1'b1, 1,  1, 1, 1, 0, 0, 0});
        vt.push_back('{1'b1, 1,  2, 1, 1, 0, 0, 0});
        vt.push_back('{1'b1, 7,  2, 1, 1, 0, 0, 0});
        vt.push_back('{1'b1, 1,  3, 1, 1, 0, 0, 0});
        vt.push_back('{1'b1, 3,  3, 1, 1, 0, 0, 0});
        vt.push_back('{1'b1, 1,  4, 1, 0, 1, 0, 0});
        vt.push_back('{1'b0, 2,  4, 1, 0, 1, 0, 0});
        vt.push_back('{1'b0, 1,  0, 0, 1, 0, 0, 1});
        vt.push_back('{1'b1, 16, 3, 1, 1, 0, 0, 1});
        vt.push_back('{1'b1, 1,  4, 1, 0, 1, 0, 1});

        do_reset();
        foreach (vt[i]) begin
            for (int k = 0; k < vt[i].n; k++) tick(vt[i].pin);
            chk($sformatf("vec%0d_state", i), int'(bus_if.state_dbg), vt[i].st);
            chk($sformatf("vec%0d_pll_resetb", i), int'(bus_if.pll_resetb), vt[i].rb);
            chk($sformatf("vec%0d_sys_reset", i), int'(bus_if.sys_reset), vt[i].sr);
            chk($sformatf("vec%0d_ready", i), int'(bus_if.ready), vt[i].rdy);
            chk($sformatf("vec%0d_tc", i), int'(bus_if.timeout_count), vt[i].tc);
            chk($sformatf("vec%0d_lc", i), int'(bus_if.lost_count), vt[i].lc);
        end

        // No lock: 4-cycle RESETB pulse every 36 cycles, timeout count saturates
        do_reset();
        for (int w = 1; w <= 16; w++) begin
            lows = 0;
            for (int e = 0; e < PRC + LT; e++) begin
                tick(1'b0);
                if (!bus_if.pll_resetb) lows++;
            end
            chk($sformatf("tmo_win%0d_low", w), lows, PRC);
            chk($sformatf("tmo_win%0d_tc", w), int'(bus_if.timeout_count), (w < SAT) ? w : SAT);
        end

        // Drop during the 5th STABLE cycle: back to WAIT_LOCK, fresh 8-cycle qualification
        do_reset();
        for (int e = 1; e <= 24; e++) begin
            tick((e == 8 || e == 9) ? 1'b0 : 1'b1);
            if (e == 10) chk("stdrop_e10_state", int'(bus_if.state_dbg), 1);
            if (e == 11) chk("stdrop_e11_state", int'(bus_if.state_dbg), 1);
            if (e == 12) chk("stdrop_e12_state", int'(bus_if.state_dbg), 2);
            if (e == 19) chk("stdrop_e19_state", int'(bus_if.state_dbg), 2);
            if (e == 20) chk("stdrop_e20_state", int'(bus_if.state_dbg), 3);
            if (e == 24) chk("stdrop_e24_ready", int'(bus_if.ready), 1);
        end
        chk("stdrop_tc", int'(bus_if.timeout_count), 0);

        // Lock arrives on the last cycle of the timeout window
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            tick((e >= 34) ? 1'b1 : 1'b0);
            if (e == 35) chk("edge_e35_state", int'(bus_if.state_dbg), 1);
            if (e == 36) chk("edge_e36_state", int'(bus_if.state_dbg), 2);
            if (e == 36) chk("edge_e36_tc", int'(bus_if.timeout_count), 0);
        end

        // Reset pulsed in HOLD and again in RUN
        do_reset();
        for (int e = 0; e < 14; e++) tick(1'b1);
        chk("hold_reached", int'(bus_if.state_dbg), 3);
        midop_reset("rst_hold");
        for (int e = 0; e < 17; e++) tick(1'b1);
        chk("run_reached", int'(bus_if.state_dbg), 4);
        midop_reset("rst_run");

        // Randomized LOCK activity with occasional resets
        for (int b = 0; b < 60; b++) begin
            v   = ($urandom_range(0, 3) != 0);
            len = v ? $urandom_range(1, 40) : $urandom_range(1, 6);
            if ($urandom_range(0, 7) == 0) begin
                v   = 1'b0;
                len = $urandom_range(30, 80);
            end
            for (int k = 0; k < len; k++) tick(v);
            if ($urandom_range(0, 19) == 0) midop_reset("rnd_rst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
